// File: rtl/instr_fetch_mem_pkg.sv
// instr_fetch_mem_pkg: shared instruction-memory constants and response error codes
// used by the fetch memory and its response FIFO.
package instr_fetch_mem_pkg;

    localparam int INSTR_WIDTH = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0) returned for faulting fetches.
    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

    localparam int INSTR_ERR_W = 2;

    typedef enum logic [INSTR_ERR_W-1:0] {
        INSTR_ERR_OK       = 2'b00,
        INSTR_ERR_MISALIGN = 2'b01,
        INSTR_ERR_RANGE    = 2'b10,
        INSTR_ERR_PARITY   = 2'b11
    } instr_err_e;

endpackage

// File: rtl/instr_rsp_fifo.sv
// instr_rsp_fifo: small synchronous FIFO holding {err, instr} fetch responses.
// A flush empties it at the clock edge, but a word pushed in that same cycle is
// kept so the redirected fetch survives. Asynchronous active-low reset.
module instr_rsp_fifo
    import instr_fetch_mem_pkg::*;
#(
    parameter  int WIDTH = INSTR_WIDTH + INSTR_ERR_W,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy, including flush handling.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (push) begin
                mem_d[0] = push_data;
                wr_ptr_d = ptr_inc('0);
                count_d  = CNT_W'(1);
            end
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: pipelined instruction memory with a valid/ready fetch port,
// a program-load write port, a LATENCY-deep read pipeline feeding a response FIFO,
// branch flush, and per-response error codes (misaligned / out of range).
// Optional macro INSTR_MEM_PARITY_EN adds one even-parity bit per word and
// reports a parity mismatch on aligned, in-range fetches.
module instr_fetch_mem
    import instr_fetch_mem_pkg::*;
#(
    parameter int DATA_W  = INSTR_WIDTH,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [1:0]        rsp_err,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int ENT_W      = DATA_W + INSTR_ERR_W;
    localparam int MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FIFO_DEPTH = LATENCY + 1;
    localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W      = 4;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef INSTR_MEM_PARITY_EN
    logic              mem_par [DEPTH];
`endif

    logic [ADDR_W-3:0] rd_idx;
    logic [ADDR_W-3:0] wr_idx;
    logic              wr_addr_unused;
    logic              accept;
    logic              pop;
    logic [ENT_W-1:0]  rd_entry;
    logic              fifo_push;
    logic [ENT_W-1:0]  fifo_push_data;
    logic              fifo_head_valid;
    logic [ENT_W-1:0]  fifo_head;
    logic [FCNT_W-1:0] fifo_count;
    logic [CNT_W-1:0]  inflight;

    assign rd_idx         = req_addr[ADDR_W-1:2];
    assign wr_idx         = wr_addr[ADDR_W-1:2];
    assign wr_addr_unused = ^wr_addr[1:0];

    // Outstanding work is bounded by the FIFO depth, so the FIFO can never overflow.
    assign req_ready = (inflight + CNT_W'(fifo_count)) < CNT_W'(FIFO_DEPTH);
    assign accept    = req_valid && req_ready;
    assign pop       = fifo_head_valid && rsp_ready;

    // Program-load port; words beyond the array are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_idx) < 32'(DEPTH))) begin
            mem[wr_idx[MEM_AW-1:0]] <= wr_data;
`ifdef INSTR_MEM_PARITY_EN
            mem_par[wr_idx[MEM_AW-1:0]] <= ^wr_data;
`endif
        end
    end

    // Array read and error classification; misalignment outranks out-of-range.
    always_comb begin
        rd_entry = {INSTR_ERR_OK, mem[rd_idx[MEM_AW-1:0]]};
        if (req_addr[1:0] != 2'b00) begin
            rd_entry = {INSTR_ERR_MISALIGN, DATA_W'(INSTR_NOP)};
        end else if (32'(rd_idx) >= 32'(DEPTH)) begin
            rd_entry = {INSTR_ERR_RANGE, DATA_W'(INSTR_NOP)};
        end
`ifdef INSTR_MEM_PARITY_EN
        else if (mem_par[rd_idx[MEM_AW-1:0]] != ^mem[rd_idx[MEM_AW-1:0]]) begin
            rd_entry = {INSTR_ERR_PARITY, mem[rd_idx[MEM_AW-1:0]]};
        end
`endif
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign inflight       = '0;
            assign fifo_push      = accept;
            assign fifo_push_data = rd_entry;
        end else begin : g_pipe
            localparam int NSTG = LATENCY - 1;

            logic [NSTG-1:0]  stg_valid_q, stg_valid_d;
            logic [ENT_W-1:0] stg_data_q [NSTG];
            logic [ENT_W-1:0] stg_data_d [NSTG];

            // Shift read results down the pipe; flush kills all but the new request.
            always_comb begin
                stg_valid_d    = '0;
                stg_data_d     = stg_data_q;
                stg_valid_d[0] = accept;
                stg_data_d[0]  = rd_entry;
                for (int i = 1; i < NSTG; i++) begin
                    stg_valid_d[i] = stg_valid_q[i-1] && !flush;
                    stg_data_d[i]  = stg_data_q[i-1];
                end
            end

            // Pipeline stage registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg_valid_q <= '0;
                    for (int i = 0; i < NSTG; i++) begin
                        stg_data_q[i] <= '0;
                    end
                end else begin
                    stg_valid_q <= stg_valid_d;
                    stg_data_q  <= stg_data_d;
                end
            end

            // Count fetches still travelling through the pipe.
            always_comb begin
                inflight = '0;
                for (int i = 0; i < NSTG; i++) begin
                    inflight = inflight + CNT_W'(stg_valid_q[i]);
                end
            end

            assign fifo_push      = stg_valid_q[NSTG-1] && !flush;
            assign fifo_push_data = stg_data_q[NSTG-1];
        end
    endgenerate

    instr_rsp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (fifo_push),
        .push_data  (fifo_push_data),
        .pop        (pop),
        .head_valid (fifo_head_valid),
        .head_data  (fifo_head),
        .count      (fifo_count)
    );

    assign rsp_valid = fifo_head_valid;
    assign rsp_instr = fifo_head[DATA_W-1:0];
    assign rsp_err   = fifo_head[DATA_W +: INSTR_ERR_W];

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: three instances (LATENCY 1, 2, 3) share one stimulus stream;
// each is compared every cycle against a transaction-level model made of a reference
// memory and a queue of expected responses with the cycle each becomes visible.
module tb_instr_fetch_mem;

    localparam int DW    = 32;
    localparam int AW    = 13;
    localparam int DEPTH = 1024;
    localparam int NDUT  = 3;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [1:0]    err;
        int            due;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          rsp_ready;
    logic          flush;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [NDUT-1:0]         req_ready_w;
    logic [NDUT-1:0]         rsp_valid_w;
    logic [NDUT-1:0][DW-1:0] rsp_instr_w;
    logic [NDUT-1:0][1:0]    rsp_err_w;

    logic [DW-1:0] ref_mem [DEPTH];
    rsp_t          exp_q [NDUT][$];
    int            cyc          = 0;
    int            assert_count = 0;
    int            fail_count   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        instr_fetch_mem #(
            .DATA_W  (DW),
            .ADDR_W  (AW),
            .DEPTH   (DEPTH),
            .LATENCY (g + 1)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_ready (req_ready_w[g]),
            .req_addr  (req_addr),
            .rsp_valid (rsp_valid_w[g]),
            .rsp_ready (rsp_ready),
            .rsp_instr (rsp_instr_w[g]),
            .rsp_err   (rsp_err_w[g]),
            .flush     (flush),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data)
        );
    end

    // What a fetch of byte address a should return, per the memory's error rules.
    function automatic rsp_t expectedFetch(input logic [AW-1:0] a, input int due);
        rsp_t r;
        r.due = due;
        if (a[1:0] != 2'b00) begin
            r.instr = NOP;
            r.err   = 2'b01;
        end else if (int'(a[AW-1:2]) >= DEPTH) begin
            r.instr = NOP;
            r.err   = 2'b10;
        end else begin
            r.instr = ref_mem[int'(a[AW-1:2])];
            r.err   = 2'b00;
        end
        return r;
    endfunction

    task automatic checkValue(input string tag, input int k, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s lat%0d cycle %0d: observed %h expected %h",
                   tag, k + 1, cyc, obs, exp);
        end
    endtask

    // Compare all instances with the model, then advance the model across the next edge.
    task automatic checkOutput();
        rsp_t head;
        logic exp_ready;
        logic exp_valid;
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_n) exp_q[k].delete();
            exp_ready = exp_q[k].size() < k + 2;
            exp_valid = (exp_q[k].size() > 0) && (cyc >= exp_q[k][0].due);
            checkValue("req_ready", k, DW'(req_ready_w[k]), DW'(exp_ready));
            checkValue("rsp_valid", k, DW'(rsp_valid_w[k]), DW'(exp_valid));
            if (!rst_n) begin
                checkValue("rsp_instr_reset", k, rsp_instr_w[k], '0);
                checkValue("rsp_err_reset", k, DW'(rsp_err_w[k]), '0);
            end else if (exp_valid) begin
                head = exp_q[k][0];
                checkValue("rsp_instr", k, rsp_instr_w[k], head.instr);
                checkValue("rsp_err", k, DW'(rsp_err_w[k]), DW'(head.err));
            end
            if (rst_n) begin
                if (exp_valid && rsp_ready) void'(exp_q[k].pop_front());
                if (flush) exp_q[k].delete();
                if (req_valid && exp_ready) exp_q[k].push_back(expectedFetch(req_addr, cyc + k + 1));
            end
        end
        if (wr_en && (int'(wr_addr[AW-1:2]) < DEPTH)) ref_mem[int'(wr_addr[AW-1:2])] = wr_data;
        cyc++;
    endtask

    // Drive one cycle of inputs, check at the falling edge, return just after the rising edge.
    task automatic applyStimulus(input logic rv, input logic [AW-1:0] ra, input logic rr,
                                 input logic fl, input logic we, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd);
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
        flush     = fl;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] ra;
        rst_n = 1'b1;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #2 rst_n = 1'b0;

        $display("[TB] reset");
        repeat (3) applyStimulus(0, '0, 1, 0, 0, '0, '0);
        rst_n = 1'b1;

        $display("[TB] program load");
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, '0, 1, 0, 1, AW'(i * 4), $urandom());
        applyStimulus(0, '0, 1, 0, 1, 13'h1000, 32'hBAD0_BAD0);
        applyStimulus(0, '0, 1, 0, 1, 13'h0004, 32'h0010_8093);

        $display("[TB] write then fetch");
        applyStimulus(1, 13'h0004, 1, 0, 0, '0, '0);
        applyStimulus(1, 13'h0000, 1, 0, 0, '0, '0);
        repeat (4) applyStimulus(0, '0, 1, 0, 0, '0, '0);

        $display("[TB] back-to-back fetches");
        for (int i = 0; i < 8; i++) applyStimulus(1, AW'(13'h0100 + i * 4), 1, 0, 0, '0, '0);
        repeat (5) applyStimulus(0, '0, 1, 0, 0, '0, '0);

        $display("[TB] error fetches");
        applyStimulus(1, 13'h0006, 1, 0, 0, '0, '0);
        applyStimulus(1, 13'h1000, 1, 0, 0, '0, '0);
        applyStimulus(1, 13'h1002, 1, 0, 0, '0, '0);
        applyStimulus(1, 13'h1FFC, 1, 0, 0, '0, '0);
        applyStimulus(1, 13'h0FFC, 1, 0, 0, '0, '0);
        repeat (5) applyStimulus(0, '0, 1, 0, 0, '0, '0);

        $display("[TB] backpressure");
        for (int i = 0; i < 7; i++) applyStimulus(1, AW'(13'h0040 + i * 4), 0, 0, 0, '0, '0);
        repeat (8) applyStimulus(0, '0, 1, 0, 0, '0, '0);

        $display("[TB] flush");
        applyStimulus(1, 13'h0060, 1, 0, 0, '0, '0);
        applyStimulus(1, 13'h0064, 1, 0, 0, '0, '0);
        applyStimulus(1, 13'h0068, 1, 0, 0, '0, '0);
        applyStimulus(1, 13'h0020, 1, 1, 0, '0, '0);
        repeat (5) applyStimulus(0, '0, 1, 0, 0, '0, '0);

        $display("[TB] read/write collision");
        applyStimulus(1, 13'h0008, 1, 0, 1, 13'h0008, 32'hDEAD_BEEF);
        applyStimulus(1, 13'h0008, 1, 0, 0, '0, '0);
        repeat (5) applyStimulus(0, '0, 1, 0, 0, '0, '0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            ra = AW'($urandom_range(0, 1040) * 4);
            if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                          AW'($urandom_range(0, 1030) * 4), $urandom());
        end
        repeat (6) applyStimulus(0, '0, 1, 0, 0, '0, '0);

        $display("[TB] reset mid-operation");
        repeat (3) applyStimulus(1, 13'h0100, 0, 0, 0, '0, '0);
        rst_n = 1'b0;
        applyStimulus(0, '0, 1, 0, 0, '0, '0);
        rst_n = 1'b1;
        applyStimulus(1, 13'h0004, 1, 0, 0, '0, '0);
        applyStimulus(1, 13'h0008, 1, 0, 0, '0, '0);
        repeat (5) applyStimulus(0, '0, 1, 0, 0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
